// File: rtl/tomasulo_inst_queue.sv
// In-order instruction issue queue feeding the Tomasulo core's instruction port.
// Circular FIFO with issue/stall statistics and a sticky hang watchdog.
module tomasulo_inst_queue #(
  parameter int DEPTH       = 8,
  parameter int STALL_LIMIT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     fetch_valid,
  input  logic [2:0]               fetch_op,
  input  logic [3:0]               fetch_rs,
  input  logic [3:0]               fetch_rt,
  input  logic [3:0]               fetch_rd,
  input  logic [31:0]              fetch_imm,
  output logic                     fetch_ready,
  output logic                     inst_valid,
  output logic [2:0]               inst_op,
  output logic [3:0]               inst_rs,
  output logic [3:0]               inst_rt,
  output logic [3:0]               inst_rd,
  output logic [31:0]              inst_imm,
  input  logic                     inst_ack,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic [15:0]              issued_count,
  output logic [15:0]              stall_cycles,
  output logic                     hang
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = $clog2(STALL_LIMIT + 1);

  logic [46:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [RW-1:0] run_cnt;
  logic          push;
  logic          pop;
  logic          stall;

  assign empty       = (count == '0);
  assign full        = (count == CW'(DEPTH));
  assign fetch_ready = !full;
  assign inst_valid  = !empty;
  assign push        = fetch_valid && fetch_ready;
  assign pop         = inst_valid && inst_ack;
  assign stall       = inst_valid && !inst_ack;

  assign {inst_op, inst_rs, inst_rt, inst_rd, inst_imm} = mem[rd_ptr];

  // Entry storage carries no reset; only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push && !flush)
      mem[wr_ptr] <= {fetch_op, fetch_rs, fetch_rt, fetch_rd, fetch_imm};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      issued_count <= '0;
      stall_cycles <= '0;
      run_cnt      <= '0;
      hang         <= 1'b0;
    end else if (flush) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      issued_count <= '0;
      stall_cycles <= '0;
      run_cnt      <= '0;
      hang         <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
      if (pop && issued_count != 16'hFFFF)
        issued_count <= issued_count + 16'd1;
      if (stall && stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
      // Run counter parks at the limit; hang latches one edge after it gets there.
      if (pop || !inst_valid)
        run_cnt <= '0;
      else if (stall && run_cnt != RW'(STALL_LIMIT))
        run_cnt <= run_cnt + RW'(1);
      if (run_cnt == RW'(STALL_LIMIT))
        hang <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tomasulo_inst_queue.sv
// Randomized and directed bench for tomasulo_inst_queue, checked against a
// queue-based reference model of the issue queue's rules.
module tb_tomasulo_inst_queue;

  localparam int DEPTH       = 8;
  localparam int STALL_LIMIT = 64;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_MUL = 3'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        fetch_valid;
  logic [2:0]  fetch_op;
  logic [3:0]  fetch_rs;
  logic [3:0]  fetch_rt;
  logic [3:0]  fetch_rd;
  logic [31:0] fetch_imm;
  logic        fetch_ready;
  logic        inst_valid;
  logic [2:0]  inst_op;
  logic [3:0]  inst_rs;
  logic [3:0]  inst_rt;
  logic [3:0]  inst_rd;
  logic [31:0] inst_imm;
  logic        inst_ack;
  logic [3:0]  count;
  logic        empty;
  logic        full;
  logic [15:0] issued_count;
  logic [15:0] stall_cycles;
  logic        hang;

  tomasulo_inst_queue #(.DEPTH(DEPTH), .STALL_LIMIT(STALL_LIMIT)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_op(fetch_op), .fetch_rs(fetch_rs),
    .fetch_rt(fetch_rt), .fetch_rd(fetch_rd), .fetch_imm(fetch_imm),
    .fetch_ready(fetch_ready), .inst_valid(inst_valid), .inst_op(inst_op),
    .inst_rs(inst_rs), .inst_rt(inst_rt), .inst_rd(inst_rd), .inst_imm(inst_imm),
    .inst_ack(inst_ack), .count(count), .empty(empty), .full(full),
    .issued_count(issued_count), .stall_cycles(stall_cycles), .hang(hang)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of entries plus plain integer statistics.
  logic [46:0] mq[$];
  int m_issued;
  int m_stalls;
  int m_run;
  bit m_hang;
  int n_checks;
  int n_fails;

  task automatic checkOutput(input string tag, input logic [46:0] got, input logic [46:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic modelClear();
    mq.delete();
    m_issued = 0;
    m_stalls = 0;
    m_run    = 0;
    m_hang   = 0;
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".count"}, 47'(count), 47'(mq.size()));
    checkOutput({tag, ".empty"}, 47'(empty), 47'(mq.size() == 0));
    checkOutput({tag, ".full"}, 47'(full), 47'(mq.size() == DEPTH));
    checkOutput({tag, ".fetch_ready"}, 47'(fetch_ready), 47'(mq.size() < DEPTH));
    checkOutput({tag, ".inst_valid"}, 47'(inst_valid), 47'(mq.size() > 0));
    checkOutput({tag, ".issued"}, 47'(issued_count), 47'(m_issued));
    checkOutput({tag, ".stalls"}, 47'(stall_cycles), 47'(m_stalls));
    checkOutput({tag, ".hang"}, 47'(hang), 47'(m_hang));
    if (mq.size() > 0)
      checkOutput({tag, ".head"}, {inst_op, inst_rs, inst_rt, inst_rd, inst_imm}, mq[0]);
  endtask

  // Drives one cycle of inputs, advances the model across the edge, then checks.
  task automatic applyStimulus(input string tag, input logic fv, input logic [46:0] e,
                               input logic ack, input logic fl);
    bit valid, do_pop, do_push, do_stall;
    fetch_valid = fv;
    {fetch_op, fetch_rs, fetch_rt, fetch_rd, fetch_imm} = e;
    inst_ack = ack;
    flush = fl;
    @(posedge clk);
    if (fl) begin
      modelClear();
    end else begin
      valid    = mq.size() > 0;
      do_pop   = valid && ack;
      do_stall = valid && !ack;
      do_push  = fv && mq.size() < DEPTH;
      if (m_run >= STALL_LIMIT) m_hang = 1;
      if (do_pop || !valid) m_run = 0;
      else if (do_stall && m_run < STALL_LIMIT) m_run++;
      if (do_pop) begin
        void'(mq.pop_front());
        if (m_issued < 65535) m_issued++;
      end
      if (do_stall && m_stalls < 65535) m_stalls++;
      if (do_push) mq.push_back(e);
    end
    @(negedge clk);
    checkAll(tag);
  endtask

  function automatic logic [46:0] randEntry();
    return {3'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 32'($urandom)};
  endfunction

  logic [46:0] e;

  initial begin
    n_checks = 0;
    n_fails  = 0;
    modelClear();
    rst = 1'b1; flush = 1'b0; fetch_valid = 1'b0; inst_ack = 1'b0;
    {fetch_op, fetch_rs, fetch_rt, fetch_rd, fetch_imm} = '0;
    repeat (2) @(negedge clk);
    checkAll("reset");
    rst = 1'b0;

    // Single ADD, held for three cycles, then issued.
    e = {OP_ADD, 4'd1, 4'd2, 4'd3, 32'd0};
    applyStimulus("add_push", 1'b1, e, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus("add_hold", 1'b0, '0, 1'b0, 1'b0);
    checkOutput("add_stalls", 47'(stall_cycles), 47'(3));
    applyStimulus("add_ack", 1'b0, '0, 1'b1, 1'b0);
    checkOutput("add_issued", 47'(issued_count), 47'(1));

    // Fill past capacity, then drain in order.
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus("fill", 1'b1, randEntry(), 1'b0, 1'b0);
    checkOutput("fill_full", 47'(full), 47'(1));
    for (int i = 0; i < DEPTH; i++) applyStimulus("drain", 1'b0, '0, 1'b1, 1'b0);
    checkOutput("drain_empty", 47'(empty), 47'(1));
    checkOutput("drain_issued", 47'(issued_count), 47'(DEPTH + 1));

    // Steady occupancy of four with push+ack every cycle, pointers wrap.
    for (int i = 0; i < 4; i++) applyStimulus("steady_fill", 1'b1, randEntry(), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus("steady", 1'b1, randEntry(), 1'b1, 1'b0);
    checkOutput("steady_count", 47'(count), 47'(4));
    for (int i = 0; i < 4; i++) applyStimulus("steady_drain", 1'b0, '0, 1'b1, 1'b0);

    // Watchdog: one MUL never accepted for STALL_LIMIT cycles.
    applyStimulus("wd_flush", 1'b0, '0, 1'b0, 1'b1);
    applyStimulus("wd_push", 1'b1, {OP_MUL, 4'd4, 4'd5, 4'd6, 32'h10}, 1'b0, 1'b0);
    for (int i = 0; i < STALL_LIMIT; i++) applyStimulus("wd_stall", 1'b0, '0, 1'b0, 1'b0);
    applyStimulus("wd_ack", 1'b0, '0, 1'b1, 1'b0);
    checkOutput("wd_hang", 47'(hang), 47'(1));
    checkOutput("wd_stalls", 47'(stall_cycles), 47'(STALL_LIMIT));

    // Flush beats a simultaneous push and pop, and clears hang.
    for (int i = 0; i < 5; i++) applyStimulus("fl_fill", 1'b1, randEntry(), 1'b0, 1'b0);
    applyStimulus("flush", 1'b1, randEntry(), 1'b1, 1'b1);
    checkOutput("flush_hang", 47'(hang), 47'(0));
    checkOutput("flush_count", 47'(count), 47'(0));

    // Asynchronous reset mid-cycle with three entries queued.
    for (int i = 0; i < 3; i++) applyStimulus("ar_fill", 1'b1, randEntry(), 1'b0, 1'b0);
    fetch_valid = 1'b0; inst_ack = 1'b0; flush = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1 modelClear();
    checkAll("async_reset");
    @(negedge clk);
    rst = 1'b0;
    e = {OP_ADD, 4'd7, 4'd8, 4'd9, 32'hDEAD_BEEF};
    applyStimulus("ar_push", 1'b1, e, 1'b0, 1'b0);
    checkOutput("ar_head", {inst_op, inst_rs, inst_rt, inst_rd, inst_imm}, e);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++)
      applyStimulus("rand", 1'($urandom_range(0, 9) < 7), randEntry(),
                    1'($urandom_range(0, 9) < 5), 1'($urandom_range(0, 99) < 3));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/tomasulo_inst_queue.md
Name: tomasulo_inst_queue

Overview:
- In-order instruction issue queue; the initiator side of the Tomasulo core's instruction interface (inst_valid / inst_* fields / inst_ack).
- Accepts decoded instructions from a fetch source or bench loader into a circular FIFO.
- Presents the head entry to the core and pops it when the core acknowledges issue.
- Provides issue and stall statistics plus a hang watchdog for when the core never accepts the head (no free reservation station, or an op the core does not issue).

Parameters:
- DEPTH, 8, queue entries; power of two, ≥2.
- STALL_LIMIT, 64, consecutive unacknowledged head cycles before hang asserts; ≥1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- flush  in  1  synchronous queue clear.
- fetch_valid  in  1  push request.
- fetch_op  in  3  opcode, same encoding as the core's inst_op.
- fetch_rs  in  4  source register 1.
- fetch_rt  in  4  source register 2.
- fetch_rd  in  4  destination register.
- fetch_imm  in  32  immediate/address.
- fetch_ready  out  1  queue can accept a push.
- inst_valid  out  1  head entry presented to the core.
- inst_op  out  3  head opcode.
- inst_rs  out  4  head rs.
- inst_rt  out  4  head rt.
- inst_rd  out  4  head rd.
- inst_imm  out  32  head immediate.
- inst_ack  in  1  core issued the head this cycle.
- count  out  $clog2(DEPTH)+1  occupancy.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- issued_count  out  16  instructions popped since reset/flush; saturating.
- stall_cycles  out  16  cycles with inst_valid=1 and inst_ack=0; saturating.
- hang  out  1  sticky watchdog flag.

Behaviour:
- Reset (rst=1, async): rd/wr pointers=0, count=0, empty=1, full=0, fetch_ready=1, inst_valid=0, issued_count=0, stall_cycles=0, hang=0, internal stall run counter=0. Entry storage is not reset; inst_* fields are don't-care while inst_valid=0.
- Storage: DEPTH×47-bit array plus rd_ptr and wr_ptr ($clog2(DEPTH) bits, natural wrap) and a count register.
- Push: occurs when fetch_valid && fetch_ready. fetch_ready = !full (combinational from registered count). No pass-through when full, even if a pop occurs in the same cycle.
- Pop: occurs when inst_valid && inst_ack. inst_ack while inst_valid=0 is ignored.
- inst_valid = !empty. inst_* are driven combinationally from array[rd_ptr]. Head fields hold stable while inst_valid=1 and no pop occurs.
- Latency: a push into an empty queue raises inst_valid the next cycle. There is no same-cycle fetch-to-inst bypass.
- Simultaneous push and pop (not full, not empty): both pointers advance, count unchanged.
- Simultaneous push and pop with count==1: head advances to the new entry, inst_valid stays 1.
- inst_ack is treated as combinational from the core, depending on inst_valid/inst_op. This block must not make inst_valid depend on inst_ack.
- issued_count increments on each pop and saturates at 16'hFFFF.
- stall_cycles increments each cycle with inst_valid && !inst_ack and saturates at 16'hFFFF.
- Watchdog run counter:
  - Increments on each stall cycle.
  - Clears on a pop or when inst_valid=0.
  - When it reaches STALL_LIMIT, hang sets next edge.
  - hang is sticky until rst or flush; the queue keeps operating while hang=1.
- flush (sync): next edge sets pointers=0, count=0, issued_count=0, stall_cycles=0, run counter=0, hang=0. A push or pop in the same cycle as flush is discarded. flush has priority over all other updates; rst has priority over flush.
- Reset mid-operation: all in-flight entries are lost and the outputs above return to reset values immediately.

Test Plan:
- Reset, then push ADD rs=1 rt=2 rd=3 imm=0 with inst_ack held 0 -> inst_valid=1 one cycle after the push, fields match, count=1. Then ack one cycle -> inst_valid=0, issued_count=1, stall_cycles equals the number of held cycles.
- Push 8 entries (DEPTH=8) with no ack -> full=1, fetch_ready=0, a 9th push is dropped. Ack 8 times -> entries pop in push order, empty=1, issued_count=8.
- Hold count=4 and push+ack every cycle for 20 cycles -> count stays 4, pointers wrap, popped order matches pushed order, issued_count=20.
- STALL_LIMIT=64: push one MUL, inst_ack=0 for 64 cycles -> hang=1 on the following edge, stall_cycles=64. Then ack -> hang remains 1 and the queue empties.
- Fill to 5 with hang=1, assert flush together with fetch_valid and inst_ack -> next cycle count=0, empty=1, hang=0, issued_count=0, stall_cycles=0.
- Assert rst asynchronously mid-cycle with count=3 -> inst_valid, count and the statistics go to 0 without waiting for a clock edge. After rst deasserts, the first push is presented correctly.
